// File: rtl/win_scan_seq.sv
// Sequential win detector: probes the four lines through the last move one cell
// per cycle and reports whether K or more of the player's stones are contiguous.
module win_scan_seq #(
  parameter int unsigned N    = 15,
  parameter int unsigned K    = 5,
  parameter int unsigned RC_W = 4,
  localparam int unsigned LEN_W = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RC_W-1:0]  row,
  input  logic [RC_W-1:0]  col,
  input  logic [N*N-1:0]   board,
  output logic             busy,
  output logic             done,
  output logic             win,
  output logic [1:0]       win_dir,
  output logic [LEN_W-1:0] run_len,
  output logic             invalid
);

  localparam int unsigned SW   = RC_W + 2;
  localparam int unsigned IDXW = $clog2(N * N);
  localparam logic signed [SW-1:0] NS  = SW'(N);
  localparam logic [LEN_W-1:0]     KL  = LEN_W'(K);
  localparam logic [RC_W-1:0]      KM1 = RC_W'(K - 1);

  typedef enum logic [2:0] {StIdle, StCenter, StScanPos, StScanNeg, StFin} state_e;

  // Coordinate move mode: 0 = stay, 1 = add step, 2 = subtract step.
  function automatic logic signed [SW-1:0] shift_coord(input logic [RC_W-1:0] b,
                                                       input logic [1:0] m,
                                                       input logic [RC_W-1:0] s);
    logic signed [SW-1:0] bx, sx;
    bx = signed'({2'b00, b});
    sx = signed'({2'b00, s});
    case (m)
      2'd1:    return bx + sx;
      2'd2:    return bx - sx;
      default: return bx;
    endcase
  endfunction

  function automatic logic [1:0] flip(input logic [1:0] m, input logic neg);
    return (neg && m != 2'd0) ? ~m : m;
  endfunction

  // Ray index = {direction, negative half}.
  function automatic logic [1:0] row_mode(input logic [2:0] ray);
    return flip((ray[2:1] == 2'd0) ? 2'd0 : 2'd1, ray[0]);
  endfunction

  function automatic logic [1:0] col_mode(input logic [2:0] ray);
    logic [1:0] m;
    case (ray[2:1])
      2'd0, 2'd2: m = 2'd1;
      2'd1:       m = 2'd0;
      default:    m = 2'd2;
    endcase
    return flip(m, ray[0]);
  endfunction

  function automatic logic target_ok(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c,
                                     input logic [2:0] ray, input logic [RC_W-1:0] s);
    logic signed [SW-1:0] tr, tc;
    tr = shift_coord(r, row_mode(ray), s);
    tc = shift_coord(c, col_mode(ray), s);
    return !tr[SW-1] && (tr < NS) && !tc[SW-1] && (tc < NS);
  endfunction

  function automatic logic [IDXW-1:0] cell_idx(input logic [RC_W-1:0] r,
                                               input logic [RC_W-1:0] c,
                                               input logic [2:0] ray,
                                               input logic [RC_W-1:0] s);
    logic signed [SW-1:0] tr, tc;
    tr = shift_coord(r, row_mode(ray), s);
    tc = shift_coord(c, col_mode(ray), s);
    return IDXW'(tr[RC_W-1:0]) * IDXW'(N) + IDXW'(tc[RC_W-1:0]);
  endfunction

  state_e           state_q, state_d;
  logic [RC_W-1:0]  row_q, row_d, col_q, col_d, step_q, step_d;
  logic [N*N-1:0]   board_q, board_d;
  logic [2:0]       ray_q, ray_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, run_len_q, run_len_d, cnt_nxt;
  logic             win_q, win_d, invalid_q, invalid_d, done_q, done_d;
  logic [1:0]       win_dir_q, win_dir_d;

  logic             occ, centre_occ, bad_coord;
  logic [IDXW-1:0]  centre_idx;
  logic             sk_found;
  logic [2:0]       sk_ray;
  logic [LEN_W-1:0] sk_cnt, sk_best;

  assign occ        = board_q[cell_idx(row_q, col_q, ray_q, step_q)];
  assign centre_idx = IDXW'(row_q) * IDXW'(N) + IDXW'(col_q);
  assign centre_occ = board_q[centre_idx];
  assign bad_coord  = ({1'b0, row_q} >= (RC_W + 1)'(N)) || ({1'b0, col_q} >= (RC_W + 1)'(N));
  assign cnt_nxt    = (state_q == StCenter) ? LEN_W'(1) : cnt_q + LEN_W'(occ);

  // Finds the next ray whose first cell is on the board, closing out any direction
  // passed over (including the ray just finished) so off-board rays cost no cycle.
  always_comb begin
    logic [2:0] jr;
    jr       = '0;
    sk_best  = run_len_q;
    sk_cnt   = cnt_nxt;
    sk_found = 1'b0;
    sk_ray   = '0;
    for (int j = 0; j < 8; j++) begin
      jr = 3'(j);
      if (!sk_found) begin
        if (state_q != StCenter && jr == ray_q) begin
          if (jr[0]) begin
            if (sk_cnt > sk_best) sk_best = sk_cnt;
            sk_cnt = LEN_W'(1);
          end
        end else if (state_q == StCenter || jr > ray_q) begin
          if (target_ok(row_q, col_q, jr, RC_W'(1))) begin
            sk_found = 1'b1;
            sk_ray   = jr;
          end else if (jr[0]) begin
            if (sk_cnt > sk_best) sk_best = sk_cnt;
            sk_cnt = LEN_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    board_d   = board_q;
    ray_d     = ray_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    run_len_d = run_len_q;
    win_d     = win_q;
    win_dir_d = win_dir_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d     = row;
          col_d     = col;
          board_d   = board;
          win_d     = 1'b0;
          win_dir_d = 2'd0;
          run_len_d = '0;
          invalid_d = 1'b0;
          state_d   = StCenter;
        end
      end
      StCenter: begin
        if (bad_coord || !centre_occ) begin
          invalid_d = bad_coord;
          state_d   = StFin;
        end else begin
          step_d    = RC_W'(1);
          cnt_d     = sk_cnt;
          run_len_d = sk_best;
          ray_d     = sk_ray;
          state_d   = !sk_found ? StFin : (sk_ray[0] ? StScanNeg : StScanPos);
        end
      end
      StScanPos, StScanNeg: begin
        if (occ && cnt_nxt == KL) begin
          win_d     = 1'b1;
          win_dir_d = ray_q[2:1];
          run_len_d = KL;
          state_d   = StFin;
        end else if (occ && step_q < KM1 &&
                     target_ok(row_q, col_q, ray_q, step_q + RC_W'(1))) begin
          cnt_d  = cnt_nxt;
          step_d = step_q + RC_W'(1);
        end else begin
          step_d    = RC_W'(1);
          cnt_d     = sk_cnt;
          run_len_d = sk_best;
          ray_d     = sk_ray;
          state_d   = !sk_found ? StFin : (sk_ray[0] ? StScanNeg : StScanPos);
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      board_q   <= '0;
      ray_q     <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      run_len_q <= '0;
      win_q     <= 1'b0;
      win_dir_q <= 2'd0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      board_q   <= board_d;
      ray_q     <= ray_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      run_len_q <= run_len_d;
      win_q     <= win_d;
      win_dir_q <= win_dir_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign win     = win_q;
  assign win_dir = win_dir_q;
  assign run_len = run_len_q;
  assign invalid = invalid_q;

endmodule
